// File: rtl/bach_avl_sched.sv
// Three-agent Avalon-MM scheduler: round-robin grant of write bursts and read commands,
// plus a tag FIFO that steers returning read beats. Optional macro: BACH_SCHED_PRIO0_EN.
module bach_avl_sched #(
  parameter int RD_DEPTH = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [2:0] req,
  input  logic [2:0] req_rd,
  input  logic [8:0] req_bcnt,
  input  logic       di_AvlWaitRequest,
  input  logic       di_AvlReadDataValid,
  output logic [2:0] grant,
  output logic [2:0] rd_route,
  output logic       rd_full,
  output logic       rd_empty,
  output logic       err_unexp_rdv
);
  localparam int PW = $clog2(RD_DEPTH);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD} state_e;

  state_e        state_q;
  logic [2:0]    grant_q;
  logic [1:0]    owner_q;
  logic [1:0]    last_q;
  logic [2:0]    beats_q;
  logic          err_q;

  logic [PW-1:0] rptr_q, wptr_q;
  logic [PW:0]   cnt_q;
  logic [1:0]    tag_agent_q [RD_DEPTH];
  logic [2:0]    tag_beats_q [RD_DEPTH];

  logic [2:0]    elig, rr_mask, sel_bcnt, sel_beats;
  logic [1:0]    cand, pick_idx;
  logic          pick_vld;
  logic          wr_accept, rd_push, rd_beat, rd_pop;

  assign rd_empty = (cnt_q == '0);
  assign rd_full  = (cnt_q == (PW+1)'(RD_DEPTH));

  // Reads are held back while the tag FIFO is full, so a push never meets a full FIFO.
  always_comb begin
    elig = req & ~(req_rd & {3{rd_full}});
`ifdef BACH_SCHED_PRIO0_EN
    rr_mask = elig[0] ? 3'b001 : (elig & 3'b110);
`else
    rr_mask = elig;
`endif
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    cand     = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      cand = 2'((int'(last_q) + k) % 3);
      if (!pick_vld && rr_mask[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
    case (pick_idx)
      2'd0:    sel_bcnt = req_bcnt[2:0];
      2'd1:    sel_bcnt = req_bcnt[5:3];
      default: sel_bcnt = req_bcnt[8:6];
    endcase
    sel_beats = (sel_bcnt == 3'd0) ? 3'd1 : sel_bcnt;
  end

  assign wr_accept = (state_q == WR_BURST) && req[owner_q] && !di_AvlWaitRequest;
  assign rd_push   = (state_q == RD_CMD) && !di_AvlWaitRequest;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= 2'd2;
      beats_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= 3'b001 << pick_idx;
            owner_q <= pick_idx;
            beats_q <= sel_beats;
            state_q <= req_rd[pick_idx] ? RD_CMD : WR_BURST;
          end
        end
        WR_BURST: begin
          if (wr_accept) begin
            if (beats_q == 3'd1) begin
              grant_q <= '0;
              last_q  <= owner_q;
              state_q <= IDLE;
            end else begin
              beats_q <= beats_q - 3'd1;
            end
          end
        end
        RD_CMD: begin
          if (rd_push) begin
            grant_q <= '0;
            last_q  <= owner_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_beat = di_AvlReadDataValid && !rd_empty;
  assign rd_pop  = rd_beat && (tag_beats_q[rptr_q] == 3'd1);

  // Depth is a power of two, so pointer increments wrap modulo RD_DEPTH naturally.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (rd_push) wptr_q <= wptr_q + PW'(1);
      if (rd_pop)  rptr_q <= rptr_q + PW'(1);
      case ({rd_push, rd_pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      err_q <= di_AvlReadDataValid && rd_empty;
    end
  end

  // NOTE: tag storage has no reset; entries are only read between valid pointers.
  always_ff @(posedge Clk) begin
    if (rd_push) begin
      tag_agent_q[wptr_q] <= owner_q;
      tag_beats_q[wptr_q] <= beats_q;
    end
    if (rd_beat && !rd_pop) tag_beats_q[rptr_q] <= tag_beats_q[rptr_q] - 3'd1;
  end

  assign grant         = grant_q;
  assign rd_route      = rd_empty ? 3'b000 : (3'b001 << tag_agent_q[rptr_q]);
  assign err_unexp_rdv = err_q;

endmodule

// File: doc/bach_avl_sched.md
BACH_AVL_SCHED -- requirements
Module: bach_avl_sched

Interface
REQ-001 Parameter RD_DEPTH, default 4, meaning maximum outstanding read bursts; legal values 2, 4 or 8.
REQ-002 Clk  input  1  the single clock; all state is updated on its rising edge.
REQ-003 Rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  3  bit i set means agent Di presents AvlRead or AvlWrite.
REQ-005 req_rd  input  3  bit i set means the Di request is a read, clear means a write.
REQ-006 req_bcnt  input  9  Di burst count at bits [3i+2:3i].
REQ-007 di_AvlWaitRequest  input  1  memory-controller stall.
REQ-008 di_AvlReadDataValid  input  1  memory-controller read beat strobe.
REQ-009 grant  output  3  one-hot registered grant; all-zero when idle.
REQ-010 rd_route  output  3  one-hot owner of the current read beat; all-zero when the tag FIFO is empty.
REQ-011 rd_full  output  1  the tag FIFO holds RD_DEPTH entries.
REQ-012 rd_empty  output  1  the tag FIFO holds 0 entries.
REQ-013 err_unexp_rdv  output  1  one-cycle pulse when di_AvlReadDataValid arrives with the FIFO empty.

Function
REQ-014 The scheduler SHALL use three states: IDLE, WR_BURST and RD_CMD.
REQ-015 In IDLE, eligible requesters SHALL be those with req set, excluding reads while rd_full is set.
REQ-016 The winner SHALL be chosen round-robin, searching upward from last_grant+1 modulo 3; last_grant resets to 2, so D0 wins first.
REQ-017 A request sampled at edge N SHALL assert grant from cycle N+1, entering RD_CMD or WR_BURST.
REQ-018 On entering WR_BURST, a 3-bit beat counter SHALL load the winner's req_bcnt; a value of 0 SHALL be treated as 1.
REQ-019 In WR_BURST, a beat is accepted on each cycle where grant is held, the owner's req is set and di_AvlWaitRequest is low; each accepted beat SHALL decrement the counter.
REQ-020 The grant SHALL be held through the whole write burst even if the owner drops req.
REQ-021 The grant SHALL be held until the last beat is accepted, then drop at the next edge, return to IDLE and update last_grant.
REQ-022 In RD_CMD, when the command is accepted (di_AvlWaitRequest low), the scheduler SHALL push {agent[1:0], bcnt}, with bcnt 0 stored as 1, into the tag FIFO.
REQ-023 In RD_CMD, on the command-accept cycle the grant SHALL drop at the next edge, the state returns to IDLE and last_grant updates.
REQ-024 The scheduler SHALL never re-grant in the same cycle that a grant drops; at least one IDLE cycle separates grants.
REQ-025 rd_route SHALL be the one-hot decode of the FIFO head agent and SHALL be purely combinational from the registered head.
REQ-026 Each di_AvlReadDataValid SHALL decrement the head remaining-beat counter; the head SHALL pop on its last beat.
REQ-027 A push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-028 The FIFO read and write pointers SHALL wrap modulo RD_DEPTH.
REQ-029 On di_AvlReadDataValid with the FIFO empty, err_unexp_rdv SHALL pulse on the next cycle, the beat is dropped, and no state changes.
REQ-030 The tag FIFO SHALL never be pushed while full; the eligibility rule in REQ-015 guarantees this.

Reset
REQ-031 While Rst is high, the scheduler SHALL clear state to IDLE, grant and rd_route to 0, set last_grant to 2, clear the FIFO pointers and counters, set rd_empty to 1 and clear rd_full and err_unexp_rdv to 0.
REQ-032 Reset asserted mid-burst SHALL abandon the burst and discard the outstanding tags, with no further rd_route after release.

Configuration
REQ-033 With BACH_SCHED_PRIO0_EN defined, an eligible D0 SHALL always win in IDLE; D1 and D2 round-robin between themselves when D0 is not eligible.
REQ-034 Without BACH_SCHED_PRIO0_EN, arbitration SHALL be pure three-way round-robin; no other behaviour differs.

Verification
REQ-035 After reset, all req=3'b111 writes with bcnt=2 and no wait: grant sequence SHALL be 001, 010, 100, each held 2 cycles, separated by 1 idle cycle.
REQ-036 D1 write with bcnt=4 and wait high on beats 2–3: grant 010 SHALL be held 6 cycles; D1 dropping req mid-burst SHALL not release the grant.
REQ-037 Five back-to-back D2 reads with bcnt=1 and RD_DEPTH=4 with no ReadDataValid: the 5th SHALL be withheld while rd_full=1, then granted one cycle after the first valid beat pops the head.
REQ-038 Reads D0 (bcnt 3) then D2 (bcnt 1), then 4 valid beats: rd_route SHALL be 001, 001, 001, 100, then 000 with rd_empty=1.
REQ-039 ReadDataValid with the FIFO empty: err_unexp_rdv SHALL be high for exactly 1 cycle.
REQ-040 With BACH_SCHED_PRIO0_EN and D0 requesting continuously: D0 SHALL win every arbitration; without the macro, D1 and D2 SHALL each win within 3 grants.
